mult_result_checker: RTL
========================

MULT_RESULT_CHECKER -- requirements
Module: mult_result_checker

Interface
REQ-001 The block SHALL have parameter WIDTH, default 2, giving the operand width of the multiplier under test.
REQ-002 The block SHALL have parameter NUM_VECTORS, default 20, giving the vectors per run; legal range 1 to 2^CNT_W-1.
REQ-003 The block SHALL have parameter CNT_W, default 16, giving the counter width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port start, input, 1 bit: begins a run; sampled in IDLE or DONE.
REQ-007 The block SHALL have port in_valid, input, 1 bit: a, b and p carry a vector.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the checker accepts a vector this cycle.
REQ-009 The block SHALL have port a, input, WIDTH bits: operand A, unsigned.
REQ-010 The block SHALL have port b, input, WIDTH bits: operand B, unsigned.
REQ-011 The block SHALL have port p, input, 2*WIDTH bits: product from the multiplier under test.
REQ-012 The block SHALL have port busy, output, 1 bit: high while in RUN.
REQ-013 The block SHALL have port done, output, 1 bit: high while in DONE.
REQ-014 The block SHALL have port pass, output, 1 bit: done and err_count equal to 0.
REQ-015 The block SHALL have port vec_count, output, CNT_W bits: vectors compared.
REQ-016 The block SHALL have port err_count, output, CNT_W bits: mismatches found.
REQ-017 The block SHALL have port first_err_valid, output, 1 bit: the first_err_* registers hold a mismatch.
REQ-018 The block SHALL have ports first_err_a (WIDTH), first_err_b (WIDTH) and first_err_p (2*WIDTH), all outputs, holding the first failing a, b and p.

Function
REQ-019 The block SHALL implement a state machine with states IDLE, RUN and DONE.
REQ-020 From IDLE or DONE, start=1 SHALL move the block to RUN and, on that same edge, clear vec_count, err_count, the accept counter and first_err_*.
REQ-021 start SHALL be ignored while the block is in RUN.
REQ-022 in_ready SHALL equal (state==RUN) AND (accept counter < NUM_VECTORS); it SHALL be 0 in IDLE and DONE.
REQ-023 A vector SHALL be accepted on an edge where in_valid=1 and in_ready=1; that edge latches a, b and p into a stage register and increments the accept counter.
REQ-024 The expected product SHALL be the full-width unsigned product a*b, 2*WIDTH bits, with no truncation.
REQ-025 On the edge after acceptance, the staged vector SHALL be compared: vec_count+1; on p != expected, err_count+1.
REQ-026 The result latency SHALL be 1 cycle from acceptance to the counter update.
REQ-027 The block SHALL sustain back-to-back acceptance at 1 vector per cycle.
REQ-028 On the first mismatch of a run only, the block SHALL load first_err_a, first_err_b and first_err_p and set first_err_valid=1; later mismatches SHALL leave these registers unchanged.
REQ-029 The block SHALL move RUN to DONE on the edge where vec_count becomes NUM_VECTORS; done and pass SHALL be valid from the following cycle.
REQ-030 in_valid=0 SHALL stall the run with no timeout; all state SHALL hold.
REQ-031 In DONE, all result outputs SHALL hold until start or rst.

Reset
REQ-032 When rst=1 at a rising clk edge, the block SHALL enter IDLE and drive in_ready=0, busy=0, done=0, pass=0, vec_count=0, err_count=0, first_err_valid=0 and first_err_a/b/p=0.
REQ-033 rst SHALL take priority over start and in_valid.
REQ-034 An rst asserted mid-run SHALL discard any staged vector without counting it.

Verification
REQ-035 Scenario: WIDTH=2, NUM_VECTORS=20, start, then 20 back-to-back correct vectors (1,2->2; 3,3->9; ...) -> done after cycle 21 of RUN, vec_count=20, err_count=0, pass=1.
REQ-036 Scenario: same run with vector 5 driven as a=3, b=2, p=5 -> err_count=1, first_err=(3,2,5), pass=0.
REQ-037 Scenario: two mismatches, (3,3,8) then (1,3,2) -> err_count=2, first_err=(3,3,8).
REQ-038 Scenario: in_valid toggled 1/0 every cycle -> run completes, vec_count=20, no vector double-counted.
REQ-039 Scenario: rst asserted after 7 vectors -> IDLE, all outputs 0; a new start then a clean run -> pass=1.
REQ-040 Scenario: in_valid held high after the 20th acceptance -> in_ready=0 and no further counting; then start from DONE -> counters cleared and busy=1.

Source files
------------

// File: rtl/mult_result_checker.sv
`default_nettype none
// ============================================================================
//  Module   : mult_result_checker
//  Purpose  : Self-checking harness for an unsigned WIDTH x WIDTH multiplier.
//             Accepts (a, b, p) vectors over a valid/ready handshake. Each
//             accepted vector is staged for one cycle and then compared with
//             the full-width product a*b. The block keeps a count of compared
//             vectors and of mismatches, and captures the first failing
//             vector of the run. A run ends after NUM_VECTORS comparisons.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH            operand width of the multiplier under test
//    NUM_VECTORS      vectors per run (1 .. 2^CNT_W-1)
//    CNT_W            width of the vector / error / accept counters
//  Ports
//    clk              clock, all state updates on the rising edge
//    rst              synchronous active-high reset
//    start            begin a run (honoured in IDLE or DONE only)
//    in_valid         a, b and p carry a vector
//    in_ready         checker accepts a vector this cycle
//    a, b             unsigned operands (WIDTH bits)
//    p                product from the multiplier under test (2*WIDTH bits)
//    busy             high while a run is in progress
//    done             high once the run has completed
//    pass             done with no mismatches
//    vec_count        vectors compared in the current / last run
//    err_count        mismatches found in the current / last run
//    first_err_valid  first_err_a/b/p hold a captured mismatch
//    first_err_a/b/p  operands and product of the first failing vector
// ============================================================================
module mult_result_checker #(
    parameter int WIDTH       = 2,
    parameter int NUM_VECTORS = 20,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [2*WIDTH-1:0]   p,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [CNT_W-1:0]     vec_count,
    output logic [CNT_W-1:0]     err_count,
    output logic                 first_err_valid,
    output logic [WIDTH-1:0]     first_err_a,
    output logic [WIDTH-1:0]     first_err_b,
    output logic [2*WIDTH-1:0]   first_err_p
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [CNT_W-1:0] c_num_vec  = CNT_W'(NUM_VECTORS);
    localparam logic [CNT_W-1:0] c_last_vec = CNT_W'(NUM_VECTORS - 1);
    localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [CNT_W-1:0]       r_acc_count;
    logic [CNT_W-1:0]       r_vec_count;
    logic [CNT_W-1:0]       r_err_count;

    logic                   r_stg_valid;
    logic [WIDTH-1:0]       r_stg_a;
    logic [WIDTH-1:0]       r_stg_b;
    logic [2*WIDTH-1:0]     r_stg_p;

    logic                   r_first_valid;
    logic [WIDTH-1:0]       r_first_a;
    logic [WIDTH-1:0]       r_first_b;
    logic [2*WIDTH-1:0]     r_first_p;

    // ------------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------------
    logic                   w_in_ready;
    logic                   w_accept;
    logic                   w_start_run;
    logic                   w_compare;
    logic                   w_mismatch;
    logic                   w_last_compare;
    logic [2*WIDTH-1:0]     w_expected;

    // A run may only be (re)started from IDLE or DONE; start during RUN is
    // deliberately ignored so a stray pulse cannot corrupt a run in flight.
    assign w_start_run    = start && (r_state != S_RUN);

    // The accept counter, not vec_count, gates in_ready: the vector staged in
    // the last accept cycle has not been compared yet, so vec_count lags by
    // one and would otherwise let one extra vector in.
    assign w_in_ready     = (r_state == S_RUN) && (r_acc_count < c_num_vec);
    assign w_accept       = in_valid && w_in_ready;

    // Operands are widened before the multiply so the full 2*WIDTH product
    // is formed with no truncation.
    assign w_expected     = (2*WIDTH)'(r_stg_a) * (2*WIDTH)'(r_stg_b);

    assign w_compare      = r_stg_valid;
    assign w_mismatch     = r_stg_valid && (r_stg_p != w_expected);
    assign w_last_compare = w_compare && (r_vec_count == c_last_vec);

    // ------------------------------------------------------------------------
    // State machine: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // State machine: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                // Leave RUN on the edge where vec_count reaches NUM_VECTORS,
                // so done/pass are visible from the following cycle.
                if (w_last_compare) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    w_state_next = S_RUN;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Accept counter: number of vectors taken in during this run
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc_count <= '0;
        end else if (w_start_run) begin
            r_acc_count <= '0;
        end else if (w_accept) begin
            r_acc_count <= r_acc_count + c_one;
        end
    end

    // ------------------------------------------------------------------------
    // Stage register: one-cycle holding slot between acceptance and compare.
    // r_stg_valid is cleared on reset and on start so that a vector in flight
    // when the run is aborted is dropped rather than counted.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stg_valid <= 1'b0;
            r_stg_a     <= '0;
            r_stg_b     <= '0;
            r_stg_p     <= '0;
        end else if (w_start_run) begin
            r_stg_valid <= 1'b0;
        end else begin
            r_stg_valid <= w_accept;
            if (w_accept) begin
                r_stg_a <= a;
                r_stg_b <= b;
                r_stg_p <= p;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Result counters
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vec_count <= '0;
            r_err_count <= '0;
        end else if (w_start_run) begin
            r_vec_count <= '0;
            r_err_count <= '0;
        end else if (w_compare) begin
            r_vec_count <= r_vec_count + c_one;
            if (w_mismatch) begin
                r_err_count <= r_err_count + c_one;
            end
        end
    end

    // ------------------------------------------------------------------------
    // First-failure capture: loaded only while first_err_valid is still low,
    // so later mismatches in the same run leave the record untouched.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_first_valid <= 1'b0;
            r_first_a     <= '0;
            r_first_b     <= '0;
            r_first_p     <= '0;
        end else if (w_start_run) begin
            r_first_valid <= 1'b0;
            r_first_a     <= '0;
            r_first_b     <= '0;
            r_first_p     <= '0;
        end else if (w_mismatch && !r_first_valid) begin
            r_first_valid <= 1'b1;
            r_first_a     <= r_stg_a;
            r_first_b     <= r_stg_b;
            r_first_p     <= r_stg_p;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign in_ready        = w_in_ready;
    assign busy            = (r_state == S_RUN);
    assign done            = (r_state == S_DONE);
    assign pass            = (r_state == S_DONE) && (r_err_count == '0);
    assign vec_count       = r_vec_count;
    assign err_count       = r_err_count;
    assign first_err_valid = r_first_valid;
    assign first_err_a     = r_first_a;
    assign first_err_b     = r_first_b;
    assign first_err_p     = r_first_p;

endmodule
`default_nettype wire
